// File: rtl/edge_pkg.sv
// edge_pkg: shared edge-mode encoding and debounce counter width helper.
package edge_pkg;
  typedef enum logic [1:0] {EM_OFF, EM_RISE, EM_FALL, EM_BOTH} edge_mode_e;
  function automatic int cw_of(input int deb);
    return ($clog2(deb + 1) < 1) ? 1 : $clog2(deb + 1);
  endfunction
endpackage

// File: rtl/edge_chan.sv
// edge_chan: one channel of synchroniser, debounce filter, edge strobes and sticky event flag.
module edge_chan
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES = 3,
  parameter int CW = cw_of(DEB_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
  input  edge_mode_e mode,
  input  logic       clr,
  output logic       level,
  output logic       en_r,
  output logic       en_f,
  output logic       evt,
  output logic       hit
);
  logic [SYNC_STAGES-1:0] sr;
  logic [CW-1:0] cnt;
  logic s, mismatch, upd, r_nxt, f_nxt;
  assign s = sr[SYNC_STAGES-1];
  assign mismatch = s ^ level;
  // the filtered level flips only after DEB_CYCLES+1 consecutive mismatching samples
  assign upd = mismatch && (cnt == CW'(DEB_CYCLES));
  assign r_nxt = upd & s & (mode == EM_RISE || mode == EM_BOTH);
  assign f_nxt = upd & ~s & (mode == EM_FALL || mode == EM_BOTH);
  assign hit = r_nxt | f_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
      cnt <= '0;
      level <= 1'b0;
      en_r <= 1'b0;
      en_f <= 1'b0;
      evt <= 1'b0;
    end else begin
      sr <= SYNC_STAGES'({sr, in});
      cnt <= (!mismatch || upd) ? '0 : cnt + 1'b1;
      level <= level ^ upd;
      en_r <= r_nxt;
      en_f <= f_nxt;
      evt <= (evt & ~clr) | hit;
    end
  end
endmodule

// File: rtl/edge2en_multi.sv
// edge2en_multi: NCH independent debounced edge-to-enable channels with a combined strobe.
module edge2en_multi
  import edge_pkg::*;
#(
  parameter int NCH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   in,
  input  logic [2*NCH-1:0] mode,
  input  logic [NCH-1:0]   clr,
  output logic [NCH-1:0]   level,
  output logic [NCH-1:0]   en_r,
  output logic [NCH-1:0]   en_f,
  output logic             en_any,
  output logic [NCH-1:0]   evt
);
  localparam int CW = cw_of(DEB_CYCLES);
  logic [NCH-1:0] hit;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    edge_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES(DEB_CYCLES),
      .CW(CW)
    ) u_chan (
      .clk(clk),
      .rst_n(rst_n),
      .in(in[i]),
      .mode(edge_mode_e'(mode[2*i+:2])),
      .clr(clr[i]),
      .level(level[i]),
      .en_r(en_r[i]),
      .en_f(en_f[i]),
      .evt(evt[i]),
      .hit(hit[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_any <= 1'b0;
    else en_any <= |hit;
  end
endmodule

// File: tb/tb_edge2en_multi.sv
// tb_edge2en_multi: directed and randomized checks against a sample-history reference model.
module tb_edge2en_multi;
  localparam int NCH = 4, SYNC = 2, DEB = 3;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic [NCH-1:0] in_r = '0, clr = '0;
  logic [2*NCH-1:0] mode = '1;
  logic [NCH-1:0] level, en_r, en_f, evt;
  logic en_any;
  int nvec = 0, errs = 0, cyc = 0;
  int tr[NCH], tf[NCH], cr[NCH], cf[NCH];
  int cany = 0;
  logic [NCH-1:0] m_lvl = '0, m_er = '0, m_ef = '0, m_evt = '0;
  logic m_any = 1'b0;
  logic [NCH-1:0] ih[$], sh[$];

  edge2en_multi #(.NCH(NCH), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_r), .mode(mode), .clr(clr),
    .level(level), .en_r(en_r), .en_f(en_f), .en_any(en_any), .evt(evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Level flips once the last DEB+1 synchronised samples since reset all disagree with it.
  task automatic model_step();
    logic [NCH-1:0] s_used, nr, nf;
    logic [1:0] md;
    bit flip;
    s_used = (ih.size() >= SYNC) ? ih[ih.size() - SYNC] : '0;
    ih.push_back(in_r);
    sh.push_back(s_used);
    nr = '0;
    nf = '0;
    for (int c = 0; c < NCH; c++) begin
      flip = sh.size() >= DEB + 1;
      for (int j = 0; j <= DEB; j++)
        if (flip && sh[sh.size() - 1 - j][c] == m_lvl[c]) flip = 0;
      if (flip) begin
        m_lvl[c] = s_used[c];
        md = mode[2*c+:2];
        nr[c] = s_used[c] && (md == 2'b01 || md == 2'b11);
        nf[c] = !s_used[c] && (md == 2'b10 || md == 2'b11);
      end
    end
    m_evt = (m_evt & ~clr) | nr | nf;
    m_er = nr;
    m_ef = nf;
    m_any = |(nr | nf);
    if (ih.size() > 40) void'(ih.pop_front());
    if (sh.size() > 40) void'(sh.pop_front());
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      ih.delete();
      sh.delete();
      m_lvl = '0; m_er = '0; m_ef = '0; m_evt = '0; m_any = 1'b0;
    end else model_step();
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (en_r[c]) begin tr[c] = cyc; cr[c]++; end
      if (en_f[c]) begin tf[c] = cyc; cf[c]++; end
    end
    if (en_any) cany++;
    if (run && rst_n) begin
      chk("level", 32'(level), 32'(m_lvl));
      chk("en_r", 32'(en_r), 32'(m_er));
      chk("en_f", 32'(en_f), 32'(m_ef));
      chk("en_any", 32'(en_any), 32'(m_any));
      chk("evt", 32'(evt), 32'(m_evt));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t0, c0, any0;
    int hold[NCH];
    for (int c = 0; c < NCH; c++) begin tr[c] = -1; tf[c] = -1; cr[c] = 0; cf[c] = 0; hold[c] = 0; end
    cycles(3);
    chk("reset_outputs", {level, en_r, en_f, evt, 15'd0, en_any}, 32'd0);
    rst_n = 1'b1;
    run = 1'b1;
    cycles(2);
    // single rising edge on channel 0
    in_r[0] = 1'b1; t0 = cyc;
    cycles(8);
    chk("rise_latency0", 32'(tr[0] - t0), 32'd6);
    chk("rise_count0", 32'(cr[0]), 32'd1);
    chk("evt0_sticky", 32'(evt[0]), 32'd1);
    cycles(12);
    // 3-cycle glitch rejected, 4-cycle pulse passes
    in_r[1] = 1'b1; cycles(3); in_r[1] = 1'b0; cycles(15);
    chk("glitch_level1", 32'(level[1]), 32'd0);
    chk("glitch_evt1", 32'(evt[1]), 32'd0);
    chk("glitch_strobes1", 32'(cr[1] + cf[1]), 32'd0);
    in_r[1] = 1'b1; t0 = cyc; cycles(4); in_r[1] = 1'b0; cycles(15);
    chk("pulse4_rise1", 32'(tr[1] - t0), 32'd6);
    chk("pulse4_gap1", 32'(tf[1] - tr[1]), 32'd4);
    // RISE-only then OFF on channel 2
    mode[5:4] = 2'b01;
    in_r[2] = 1'b1; cycles(15); in_r[2] = 1'b0; cycles(15);
    chk("rise_only_r2", 32'(cr[2]), 32'd1);
    chk("rise_only_f2", 32'(cf[2]), 32'd0);
    chk("rise_only_lvl2", 32'(level[2]), 32'd0);
    mode[5:4] = 2'b00;
    clr[2] = 1'b1; cycles(1); clr[2] = 1'b0;
    in_r[2] = 1'b1; cycles(15); in_r[2] = 1'b0; cycles(15);
    chk("off_evt2", 32'(evt[2]), 32'd0);
    chk("off_strobes2", 32'(cr[2] + cf[2]), 32'd1);
    mode = '1;
    // clr coincident with a new falling strobe: set wins
    in_r[0] = 1'b0; cycles(5);
    clr[0] = 1'b1; cycles(1); clr[0] = 1'b0;
    chk("clr_vs_set_enf0", 32'(en_f[0]), 32'd1);
    chk("clr_vs_set_evt0", 32'(evt[0]), 32'd1);
    clr[0] = 1'b1; cycles(1); clr[0] = 1'b0;
    chk("clr_alone_evt0", 32'(evt[0]), 32'd0);
    cycles(10);
    // simultaneous rises on channels 0 and 3
    any0 = cany; t0 = cyc;
    in_r[0] = 1'b1; in_r[3] = 1'b1; cycles(10);
    chk("simul_r0_r3", 32'(tr[3] - tr[0]), 32'd0);
    chk("simul_lat", 32'(tr[0] - t0), 32'd6);
    chk("simul_any_once", 32'(cany - any0), 32'd1);
    in_r[0] = 1'b0; in_r[3] = 1'b0; cycles(12);
    // reset mid-debounce
    c0 = cr[0];
    in_r[0] = 1'b1; cycles(3);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {level, en_r, en_f, evt, 15'd0, en_any}, 32'd0);
    cycles(2);
    rst_n = 1'b1; t0 = cyc;
    cycles(10);
    chk("post_reset_latency0", 32'(tr[0] - t0), 32'd6);
    chk("post_reset_rise_once", 32'(cr[0] - c0), 32'd1);
    // randomized phase
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if (hold[c] == 0) begin
          in_r[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 9);
        end else hold[c]--;
        clr[c] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 63) == 0) mode = 8'($urandom);
      cycles(1);
    end
    clr = '0;
    cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule

// File: doc/edge2en_multi.md
Name: edge2en_multi

Overview:
- Parametrised successor to the single-bit Rising2En/Edge2En edge-to-enable blocks.
- Takes NCH asynchronous inputs and synchronises each through SYNC_STAGES flops.
- Each channel has a digital debounce filter and a per-channel runtime edge mode (off/rising/falling/both).
- Produces single-cycle enable strobes, a filtered level, and sticky, software-clearable event flags; sits between raw pins/buttons and control FSMs.

Parameters:
- NCH, 4, number of independent channels (>=1).
- SYNC_STAGES, 2, synchroniser depth per channel (>=1).
- DEB_CYCLES, 3, extra consecutive mismatch cycles required before the filtered level flips; 0 = no filtering.
- CW, $clog2(DEB_CYCLES+1) (min 1), debounce counter width (derived, localparam).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in  in  NCH  raw asynchronous inputs.
- mode  in  2*NCH  per-channel edge_mode_e: 00 OFF, 01 RISE, 10 FALL, 11 BOTH (synchronous to clk).
- clr  in  NCH  per-channel sticky-flag clear, one-cycle strobe.
- level  out  NCH  debounced, synchronised level.
- en_r  out  NCH  one-cycle rising-edge strobe (mode RISE/BOTH).
- en_f  out  NCH  one-cycle falling-edge strobe (mode FALL/BOTH).
- en_any  out  1  OR of all en_r and en_f.
- evt  out  NCH  sticky flag, set by any en_r/en_f on that channel.

Behaviour:
- Reset (async assert, sync deassert handled upstream): all sync flops, counters, level, en_r, en_f, en_any and evt are 0.
- Synchroniser: in[i] shifts through SYNC_STAGES flops; s[i] is the last stage.
- Debounce per channel, evaluated each edge:
  - mismatch = (s != level).
  - If !mismatch: cnt <= 0.
  - Else if cnt == DEB_CYCLES: level <= s, cnt <= 0.
  - Else: cnt <= cnt + 1.
  - Counter never wraps.
- Latency: an input change that is stable before edge 1 appears on level at edge SYNC_STAGES+DEB_CYCLES+1.
- Glitch rejection: an input pulse lasting <= DEB_CYCLES cycles at s leaves level unchanged and generates no strobe.
- Strobes are registered and coincide with the cycle in which level shows its new value:
  - en_r[i] <= level_update & s & (mode[i] == RISE | mode[i] == BOTH).
  - en_f[i] <= level_update & ~s & (mode[i] == FALL | mode[i] == BOTH).
  - Each strobe is high for exactly one cycle per level transition.
- mode is sampled on the same edge as level_update. A mode change mid-debounce does not reset cnt. OFF channels still track level.
- en_any is a registered OR, aligned with en_r/en_f.
- evt[i] <= (evt[i] & ~clr[i]) | en_r_next[i] | en_f_next[i]. Set wins over a simultaneous clr. evt rises in the same cycle as the strobe.
- Channels are fully independent; simultaneous events on multiple channels are all reported.
- Reset asserted mid-debounce aborts the count. After release, level=0; an input already high produces a rising edge after the full latency.

Decomposition:
- Package edge_pkg: typedef enum logic [1:0] edge_mode_e {EM_OFF, EM_RISE, EM_FALL, EM_BOTH}; function cw_of(deb) returning max(1, $clog2(deb+1)).
- Sub-module edge_chan handles one channel: synchroniser, debounce counter, level, strobes and evt. The top generate-loops NCH instances and builds en_any.

Test Plan:
- NCH=4, SYNC=2, DEB=3, all modes BOTH: in[0] 0->1, held 20 cycles -> level[0] and en_r[0] rise exactly 6 edges later; en_r[0] lasts 1 cycle; evt[0]=1 and stays set.
- in[1] high for 3 cycles then low -> level[1], en_r[1], en_f[1] and evt[1] remain 0 throughout. Repeat with a 4-cycle pulse -> en_r[1] pulse, then en_f[1] 4 cycles after it.
- mode[2]=RISE: in[2] 0->1->0 with long holds -> en_r[2] pulses, no en_f[2]; level[2] still tracks both edges. mode[2]=OFF -> no strobes, no evt.
- evt[0]=1 with clr[0] pulsed on the same cycle as a new en_f[0] -> evt[0] stays 1. Next clr[0] alone -> evt[0]=0 on the following cycle.
- in[0] and in[3] rise on the same cycle -> en_r[0] and en_r[3] in the same cycle; en_any high for that single cycle.
- in[0] held high, rst_n pulsed low mid-debounce -> all outputs 0 immediately. After release, en_r[0] fires 6 edges later.
